// File: rtl/ahb_slave_if_if.sv
// AHB bus bundle between the master and the AHB-to-APB bridge front end.
// The master modport drives the request; the slave modport returns the response and read data.
interface ahb_slave_if_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              HSELAPBif;
    logic              HREADYin;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [ADDR_W-1:0] HADDR;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADYout;
    logic [1:0]        HRESP;
    logic [DATA_W-1:0] HRDATA;

    modport master (
        output HSELAPBif, HREADYin, HTRANS, HWRITE, HSIZE, HADDR, HWDATA,
        input  HREADYout, HRESP, HRDATA
    );

    modport slave (
        input  HSELAPBif, HREADYin, HTRANS, HWRITE, HSIZE, HADDR, HWDATA,
        output HREADYout, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_slave_if.sv
// AHB-side front end of the AHB-to-APB bridge: qualifies transfers, decodes the
// peripheral select, pipelines address/data/direction two deep and drives HREADYout/HRESP.
module ahb_slave_if #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                NUM_SLV  = 3,
    parameter logic [ADDR_W-1:0] SLV_BASE = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] SLV_SPAN = 32'h0400_0000
) (
    input  logic               clock,
    input  logic               HRESETn,
    ahb_slave_if_if.slave      ahb,
    input  logic               apb_ready,
    input  logic [DATA_W-1:0]  prdata,
    output logic               valid,
    output logic [ADDR_W-1:0]  haddr1,
    output logic [ADDR_W-1:0]  haddr2,
    output logic [DATA_W-1:0]  hwdata1,
    output logic [DATA_W-1:0]  hwdata2,
    output logic               hwrite_reg,
    output logic               hwrite_reg1,
    output logic [NUM_SLV-1:0] tempselx
);

    typedef enum logic [1:0] {
        ST_OKAY = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } resp_state_t;

    resp_state_t        state_r;
    resp_state_t        state_s;
    logic               hready_s;
    logic [1:0]         hresp_s;
    logic               active_s;
    logic               size_ok_s;
    logic               in_map_s;
    logic               bad_s;
    logic [NUM_SLV-1:0] sel_s;
    logic [ADDR_W-1:0]  haddr1_r;
    logic [ADDR_W-1:0]  haddr2_r;
    logic [DATA_W-1:0]  hwdata1_r;
    logic [DATA_W-1:0]  hwdata2_r;
    logic               hwrite1_r;
    logic               hwrite2_r;

    assign active_s  = ahb.HSELAPBif & ahb.HREADYin & ahb.HTRANS[1];
    assign size_ok_s = (ahb.HSIZE == 3'b010);
    assign in_map_s  = |sel_s;
    assign bad_s     = active_s & (~in_map_s | ~size_ok_s);

    // Peripheral window decode; one extra bit keeps the top window from wrapping.
    always_comb begin
        logic [ADDR_W:0] addr_v;
        logic [ADDR_W:0] lo_v;
        logic [ADDR_W:0] hi_v;
        sel_s  = '0;
        addr_v = {1'b0, ahb.HADDR};
        lo_v   = '0;
        hi_v   = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            lo_v = {1'b0, SLV_BASE} + ((ADDR_W+1)'(i) * {1'b0, SLV_SPAN});
            hi_v = lo_v + {1'b0, SLV_SPAN};
            if ((addr_v >= lo_v) && (addr_v < hi_v)) begin
                sel_s[i] = 1'b1;
            end else begin
                sel_s[i] = 1'b0;
            end
        end
    end

    // Response FSM state register.
    always_ff @(posedge clock or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r <= ST_OKAY;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and response; an error is only raised on a completing cycle.
    always_comb begin
        state_s  = state_r;
        hready_s = apb_ready;
        hresp_s  = 2'b00;
        case (state_r)
            ST_OKAY: begin
                hready_s = apb_ready;
                hresp_s  = 2'b00;
                if (bad_s && apb_ready) begin
                    state_s = ST_ERR1;
                end else begin
                    state_s = ST_OKAY;
                end
            end
            ST_ERR1: begin
                hready_s = 1'b0;
                hresp_s  = 2'b01;
                state_s  = ST_ERR2;
            end
            ST_ERR2: begin
                hready_s = 1'b1;
                hresp_s  = 2'b01;
                state_s  = ST_OKAY;
            end
            default: begin
                hready_s = apb_ready;
                hresp_s  = 2'b00;
                state_s  = ST_OKAY;
            end
        endcase
    end

    // Two-deep address/data/direction pipeline, frozen while the bus is stalled.
    always_ff @(posedge clock or negedge HRESETn) begin
        if (!HRESETn) begin
            haddr1_r  <= '0;
            haddr2_r  <= '0;
            hwdata1_r <= '0;
            hwdata2_r <= '0;
            hwrite1_r <= 1'b0;
            hwrite2_r <= 1'b0;
        end else if (hready_s) begin
            haddr1_r  <= ahb.HADDR;
            haddr2_r  <= haddr1_r;
            hwdata1_r <= ahb.HWDATA;
            hwdata2_r <= hwdata1_r;
            hwrite1_r <= ahb.HWRITE;
            hwrite2_r <= hwrite1_r;
        end
    end

    assign valid         = active_s & in_map_s & size_ok_s & (state_r == ST_OKAY);
    assign tempselx      = sel_s;
    assign haddr1        = haddr1_r;
    assign haddr2        = haddr2_r;
    assign hwdata1       = hwdata1_r;
    assign hwdata2       = hwdata2_r;
    assign hwrite_reg    = hwrite1_r;
    assign hwrite_reg1   = hwrite2_r;
    assign ahb.HREADYout = hready_s;
    assign ahb.HRESP     = hresp_s;
    assign ahb.HRDATA    = prdata;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Self-checking bench for ahb_slave_if: directed scenarios plus a randomized run
// compared against a transaction-level reference model of the bridge front end.
module tb_ahb_slave_if;

    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [63:0] SPAN = 64'h0400_0000;

    logic        clock;
    logic        HRESETn;
    logic        apb_ready;
    logic [31:0] prdata;
    logic        valid;
    logic [31:0] haddr1, haddr2, hwdata1, hwdata2;
    logic        hwrite_reg, hwrite_reg1;
    logic [2:0]  tempselx;

    int errors = 0;
    int checks = 0;

    // Reference model: pipeline contents and remaining error-response cycles.
    logic [31:0] m_a1, m_a2, m_d1, m_d2;
    logic        m_w1, m_w2;
    int          m_err;

    ahb_slave_if_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ahb_slave_if dut (
        .clock       (clock),
        .HRESETn     (HRESETn),
        .ahb         (bus),
        .apb_ready   (apb_ready),
        .prdata      (prdata),
        .valid       (valid),
        .haddr1      (haddr1),
        .haddr2      (haddr2),
        .hwdata1     (hwdata1),
        .hwdata2     (hwdata2),
        .hwrite_reg  (hwrite_reg),
        .hwrite_reg1 (hwrite_reg1),
        .tempselx    (tempselx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [2:0] exp_sel(input logic [31:0] a);
        logic [63:0] ae;
        logic [2:0]  s;
        int          idx;
        ae = {32'd0, a};
        s  = 3'b000;
        if (ae >= BASE && ae < BASE + 64'd3 * SPAN) begin
            idx = int'((ae - BASE) / SPAN);
            s[idx] = 1'b1;
        end
        return s;
    endfunction

    function automatic logic m_active();
        return bus.HSELAPBif && bus.HREADYin && (bus.HTRANS == 2'b10 || bus.HTRANS == 2'b11);
    endfunction

    function automatic logic m_hready();
        if (m_err == 2) return 1'b0;
        if (m_err == 1) return 1'b1;
        return apb_ready;
    endfunction

    function automatic logic [1:0] m_hresp();
        return (m_err != 0) ? 2'b01 : 2'b00;
    endfunction

    function automatic logic m_valid();
        return m_active() && exp_sel(bus.HADDR) != 3'b000 && bus.HSIZE == 3'b010 && m_err == 0;
    endfunction

    task automatic model_reset();
        m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0;
        m_w1 = 1'b0; m_w2 = 1'b0; m_err = 0;
    endtask

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic tick();
        logic hr, bad;
        @(posedge clock);
        if (HRESETn) begin
            hr  = m_hready();
            bad = m_active() && (exp_sel(bus.HADDR) == 3'b000 || bus.HSIZE != 3'b010);
            if (hr) begin
                m_a2 = m_a1; m_a1 = bus.HADDR;
                m_d2 = m_d1; m_d1 = bus.HWDATA;
                m_w2 = m_w1; m_w1 = bus.HWRITE;
            end
            if (m_err == 2)           m_err = 1;
            else if (m_err == 1)      m_err = 0;
            else if (bad && hr)       m_err = 2;
        end
        #1;
    endtask

    task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        bus.HSELAPBif = sel;
        bus.HREADYin  = 1'b1;
        bus.HTRANS    = trans;
        bus.HWRITE    = wr;
        bus.HSIZE     = size;
        bus.HADDR     = addr;
        bus.HWDATA    = wdata;
        #1;
    endtask

    task automatic go_idle();
        drive(1'b0, 2'b00, 1'b0, 3'b010, 32'h0000_0000, 32'h0000_0000);
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        apb_ready = 1'b1;
        prdata = 32'h1234_5678;
        model_reset();
        drive(1'b1, 2'b10, 1'b1, 3'b010, 32'h9000_0000, 32'hDEAD_BEEF);
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (haddr1 !== 32'h0 || haddr2 !== 32'h0) begin errors++; $display("FAIL reset_haddr: got %h/%h want 0/0", haddr1, haddr2); end
        checks++; if (bus.HRESP !== 2'b00) begin errors++; $display("FAIL reset_hresp: got %b want 00", bus.HRESP); end
        checks++; if (bus.HREADYout !== 1'b1) begin errors++; $display("FAIL reset_hready1: got %b want 1", bus.HREADYout); end
        apb_ready = 1'b0;
        #1;
        checks++; if (bus.HREADYout !== 1'b0) begin errors++; $display("FAIL reset_hready0: got %b want 0", bus.HREADYout); end
        apb_ready = 1'b1;
        go_idle();
        tick();
        HRESETn = 1'b1;
        tick();
    endtask

    task automatic test_write();
        drive(1'b1, 2'b10, 1'b1, 3'b010, 32'h8400_0010, 32'hA5A5_0001);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL wr_valid: got %b want 1", valid); end
        checks++; if (tempselx !== 3'b010) begin errors++; $display("FAIL wr_sel: got %b want 010", tempselx); end
        tick();
        checks++; if (haddr1 !== 32'h8400_0010) begin errors++; $display("FAIL wr_haddr1: got %h want 84000010", haddr1); end
        go_idle();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", valid); end
        tick();
        checks++; if (hwdata2 !== 32'hA5A5_0001) begin errors++; $display("FAIL wr_hwdata2: got %h want A5A50001", hwdata2); end
        checks++; if (hwrite_reg1 !== 1'b1) begin errors++; $display("FAIL wr_hwrite1: got %b want 1", hwrite_reg1); end
        checks++; if (haddr2 !== 32'h8400_0010) begin errors++; $display("FAIL wr_haddr2: got %h want 84000010", haddr2); end
    endtask

    task automatic test_back_to_back();
        apb_ready = 1'b1;
        drive(1'b1, 2'b10, 1'b0, 3'b010, 32'h8000_0000, 32'h0);
        checks++; if (tempselx !== 3'b001) begin errors++; $display("FAIL b2b_sel: got %b want 001", tempselx); end
        tick();
        apb_ready = 1'b0;
        drive(1'b1, 2'b11, 1'b0, 3'b010, 32'h8000_0004, 32'h0);
        for (int k = 0; k < 2; k++) begin
            checks++; if (bus.HREADYout !== 1'b0) begin errors++; $display("FAIL b2b_stall_hready: got %b want 0", bus.HREADYout); end
            tick();
            checks++; if (haddr1 !== 32'h8000_0000) begin errors++; $display("FAIL b2b_hold_haddr1: got %h want 80000000", haddr1); end
        end
        apb_ready = 1'b1;
        #1;
        checks++; if (bus.HREADYout !== 1'b1) begin errors++; $display("FAIL b2b_release_hready: got %b want 1", bus.HREADYout); end
        tick();
        checks++; if (haddr1 !== 32'h8000_0004 || haddr2 !== 32'h8000_0000) begin errors++; $display("FAIL b2b_advance: got %h/%h want 80000004/80000000", haddr1, haddr2); end
        go_idle();
        tick();
    endtask

    task automatic test_addr_error();
        drive(1'b1, 2'b10, 1'b1, 3'b010, 32'h9000_0000, 32'h0);
        checks++; if (valid !== 1'b0 || tempselx !== 3'b000) begin errors++; $display("FAIL err_valid: got %b/%b want 0/000", valid, tempselx); end
        tick();
        go_idle();
        checks++; if (bus.HREADYout !== 1'b0 || bus.HRESP !== 2'b01) begin errors++; $display("FAIL err1: got %b/%b want 0/01", bus.HREADYout, bus.HRESP); end
        tick();
        checks++; if (bus.HREADYout !== 1'b1 || bus.HRESP !== 2'b01) begin errors++; $display("FAIL err2: got %b/%b want 1/01", bus.HREADYout, bus.HRESP); end
        tick();
        checks++; if (bus.HRESP !== 2'b00) begin errors++; $display("FAIL err_back_okay: got %b want 00", bus.HRESP); end
        // Boundary just past the last peripheral window must also be rejected.
        drive(1'b1, 2'b10, 1'b0, 3'b010, 32'h8BFF_FFFC, 32'h0);
        checks++; if (valid !== 1'b1 || tempselx !== 3'b100) begin errors++; $display("FAIL top_edge_in: got %b/%b want 1/100", valid, tempselx); end
        drive(1'b1, 2'b10, 1'b0, 3'b010, 32'h8C00_0000, 32'h0);
        checks++; if (valid !== 1'b0 || tempselx !== 3'b000) begin errors++; $display("FAIL top_edge_out: got %b/%b want 0/000", valid, tempselx); end
        go_idle();
    endtask

    task automatic test_size_error_busy();
        drive(1'b1, 2'b10, 1'b0, 3'b000, 32'h8800_0000, 32'h0);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL size_valid: got %b want 0", valid); end
        tick();
        go_idle();
        checks++; if (bus.HREADYout !== 1'b0 || bus.HRESP !== 2'b01) begin errors++; $display("FAIL size_err1: got %b/%b want 0/01", bus.HREADYout, bus.HRESP); end
        tick();
        checks++; if (bus.HREADYout !== 1'b1 || bus.HRESP !== 2'b01) begin errors++; $display("FAIL size_err2: got %b/%b want 1/01", bus.HREADYout, bus.HRESP); end
        tick();
        drive(1'b1, 2'b01, 1'b0, 3'b010, 32'h8800_0000, 32'h0);
        checks++; if (valid !== 1'b0 || bus.HRESP !== 2'b00) begin errors++; $display("FAIL busy: got %b/%b want 0/00", valid, bus.HRESP); end
        tick();
        checks++; if (bus.HRESP !== 2'b00 || bus.HREADYout !== 1'b1) begin errors++; $display("FAIL busy_after: got %b/%b want 00/1", bus.HRESP, bus.HREADYout); end
        go_idle();
    endtask

    task automatic test_reset_in_err();
        apb_ready = 1'b1;
        drive(1'b1, 2'b10, 1'b1, 3'b010, 32'h0000_1000, 32'h0);
        tick();
        go_idle();
        checks++; if (bus.HRESP !== 2'b01) begin errors++; $display("FAIL rst_err_enter: got %b want 01", bus.HRESP); end
        HRESETn = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.HRESP !== 2'b00 || bus.HREADYout !== 1'b1) begin errors++; $display("FAIL rst_err_hresp: got %b/%b want 00/1", bus.HRESP, bus.HREADYout); end
        checks++; if (haddr1 !== 32'h0 || hwdata1 !== 32'h0) begin errors++; $display("FAIL rst_err_pipe: got %h/%h want 0/0", haddr1, hwdata1); end
        tick();
        HRESETn = 1'b1;
        tick();
        drive(1'b1, 2'b10, 1'b0, 3'b010, 32'h8400_0000, 32'h0);
        checks++; if (valid !== 1'b1 || bus.HRESP !== 2'b00) begin errors++; $display("FAIL rst_err_after: got %b/%b want 1/00", valid, bus.HRESP); end
        tick();
        go_idle();
        tick();
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 7))
                0: a = 32'h8000_0000;
                1: a = 32'h7FFF_FFFC;
                2: a = 32'h83FF_FFFC;
                3: a = 32'h8400_0000;
                4: a = 32'h8C00_0000;
                5: a = $urandom;
                default: a = 32'h8000_0000 + ($urandom_range(0, 32'h0BFF_FFFF) & 32'hFFFF_FFFC);
            endcase
            bus.HSELAPBif = ($urandom_range(0, 7) != 0);
            bus.HREADYin  = ($urandom_range(0, 7) != 0);
            bus.HTRANS    = 2'($urandom_range(0, 3));
            bus.HWRITE    = 1'($urandom_range(0, 1));
            bus.HSIZE     = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
            bus.HADDR     = a;
            bus.HWDATA    = $urandom;
            apb_ready     = ($urandom_range(0, 3) != 0);
            prdata        = $urandom;
            #1;
            checks++; if (valid !== m_valid()) begin errors++; $display("FAIL rnd_valid n=%0d: got %b want %b", n, valid, m_valid()); end
            checks++; if (tempselx !== exp_sel(a)) begin errors++; $display("FAIL rnd_sel n=%0d: got %b want %b", n, tempselx, exp_sel(a)); end
            checks++; if (bus.HREADYout !== m_hready() || bus.HRESP !== m_hresp()) begin errors++; $display("FAIL rnd_resp n=%0d: got %b/%b want %b/%b", n, bus.HREADYout, bus.HRESP, m_hready(), m_hresp()); end
            checks++; if (bus.HRDATA !== prdata) begin errors++; $display("FAIL rnd_hrdata n=%0d: got %h want %h", n, bus.HRDATA, prdata); end
            tick();
            checks++; if (haddr1 !== m_a1 || haddr2 !== m_a2) begin errors++; $display("FAIL rnd_haddr n=%0d: got %h/%h want %h/%h", n, haddr1, haddr2, m_a1, m_a2); end
            checks++; if (hwdata1 !== m_d1 || hwdata2 !== m_d2) begin errors++; $display("FAIL rnd_hwdata n=%0d: got %h/%h want %h/%h", n, hwdata1, hwdata2, m_d1, m_d2); end
            checks++; if (hwrite_reg !== m_w1 || hwrite_reg1 !== m_w2) begin errors++; $display("FAIL rnd_hwrite n=%0d: got %b/%b want %b/%b", n, hwrite_reg, hwrite_reg1, m_w1, m_w2); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_back_to_back();
        test_addr_error();
        test_size_error_busy();
        test_reset_in_err();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
